// File: rtl/bus_memory_responder.sv
// Memory-side responder for a 32-bit CPU bus: word RAM, an I/O page (output
// latch, timer, ID word) and a power-on sequencer that zeroes the RAM.
module bus_memory_responder #(
  parameter int          ADDR_BITS = 8,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_FF00,
  parameter logic [31:0] ID_WORD   = 32'h4A49_4630
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] datai,
  input  logic        rw,
  output logic [31:0] data,
  output logic        busy,
  output logic [31:0] io_out,
  output logic        io_strobe,
  output logic        bus_error
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Bus handshake: there is no valid/ready pair. Every RUN cycle is one access
  // (rw=1 read, rw=0 write); read data appears on data one cycle later.
  typedef enum logic {CLEAR, RUN} state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   ptr;
  logic [31:0]            timer;
  logic [31:0]            mem [DEPTH];

  logic                   is_io;
  logic                   is_ram;
  logic [7:0]             offset;
  logic [ADDR_BITS-1:0]   index;
  logic [31:0]            io_rdata;
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [31:0]            mem_wdata;

  // The I/O page takes priority over the RAM window in decode.
  always_comb begin
    is_io  = (address[31:8] == IO_BASE[31:8]);
    is_ram = !is_io && (address[31:ADDR_BITS] == '0);
    offset = address[7:0];
    index  = address[ADDR_BITS-1:0];

    io_rdata = 32'd0;
    case (offset)
      8'd0:    io_rdata = io_out;
      8'd1:    io_rdata = timer;
      8'd2:    io_rdata = ID_WORD;
      default: io_rdata = 32'd0;
    endcase

    mem_we    = 1'b0;
    mem_waddr = index;
    mem_wdata = datai;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr;
      mem_wdata = 32'd0;
    end else begin
      mem_we = !rw && is_ram;
    end
  end

  // Single write port shared by the clear sequencer and bus writes.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      ptr       <= '0;
      busy      <= 1'b1;
      data      <= 32'd0;
      io_out    <= 32'd0;
      io_strobe <= 1'b0;
      bus_error <= 1'b0;
      timer     <= 32'd0;
    end else begin
      io_strobe <= 1'b0;
      case (state)
        CLEAR: begin
          ptr   <= ptr + ADDR_BITS'(1);
          timer <= 32'd0;
          data  <= 32'd0;
          if (ptr == '1) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          timer <= timer + 32'd1;
          if (rw) begin
            if (is_io) begin
              data <= io_rdata;
            end else if (is_ram) begin
              data <= mem[index];
            end else begin
              data      <= 32'd0;
              bus_error <= 1'b1;
            end
          end else begin
            if (is_io) begin
              if (offset == 8'd0) begin
                io_out    <= datai;
                io_strobe <= 1'b1;
              end else if (offset == 8'd1) begin
                timer <= datai;  // a bus write overrides this cycle's increment
              end
            end else if (!is_ram) begin
              bus_error <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
